relin_tile_feeder: RTL and testbench

//  Transmit side of the relinearization coefficient stream. Holds one c2 polynomial
//  (C2_WIDTH coeffs) in a local buffer, then streams it tile-by-tile (C2_TILE_WIDTH

---
 rtl/relin_pkg.sv | 19 +
 rtl/relin_tile_buffer.sv | 36 +++
 rtl/relin_tile_feeder.sv | 169 ++++++++++++++++
 tb/tb_relin_tile_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/relin_pkg.sv
// Shared types and default sizing for the relinearization tile feeder.
package relin_pkg;

    localparam int unsigned RELIN_DATA_WIDTH    = 64;
    localparam int unsigned RELIN_C2_WIDTH      = 512;
    localparam int unsigned RELIN_C2_TILE_WIDTH = 8;
    localparam int unsigned RELIN_NUM_TILES     = RELIN_C2_WIDTH / RELIN_C2_TILE_WIDTH;

    typedef logic [RELIN_DATA_WIDTH-1:0] coeff_t;
    // Element 0 of a tile occupies the least-significant coefficient slot.
    typedef coeff_t [RELIN_C2_TILE_WIDTH-1:0] tile_t;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StWaitDone
    } feeder_state_e;

endpackage

// File: rtl/relin_tile_buffer.sv
// Coefficient buffer: single-coefficient write port, whole-tile combinational read port.
module relin_tile_buffer #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned C2_WIDTH      = 512,
    parameter int unsigned C2_TILE_WIDTH = 8
) (
    input  logic                                    clk_i,
    input  logic                                    we_i,
    input  logic [$clog2(C2_WIDTH)-1:0]             waddr_i,
    input  logic [DATA_WIDTH-1:0]                   wdata_i,
    input  logic [$clog2(C2_WIDTH/C2_TILE_WIDTH)-1:0] rd_tile_idx_i,
    output logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] rd_tile_o
);

    localparam int unsigned AddrW = $clog2(C2_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [C2_WIDTH];
    logic [AddrW-1:0]      rd_base;

    assign rd_base = AddrW'(rd_tile_idx_i) * AddrW'(C2_TILE_WIDTH);

    // Storage write; contents deliberately have no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Gather the addressed tile, lowest coefficient index into slot 0.
    always_comb begin
        for (int i = 0; i < int'(C2_TILE_WIDTH); i++) begin
            rd_tile_o[i] = mem_q[rd_base + AddrW'(i)];
        end
    end

endmodule

// File: rtl/relin_tile_feeder.sv
// Streams a buffered c2 polynomial tile-by-tile into relin_unit over valid/ready.
// Optional build macro RELIN_FEEDER_DUAL_PASS_EN: each start runs key 0 then key 1.
module relin_tile_feeder
    import relin_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = RELIN_DATA_WIDTH,
    parameter int unsigned C2_WIDTH      = RELIN_C2_WIDTH,
    parameter int unsigned C2_TILE_WIDTH = RELIN_C2_TILE_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en_i,
    input  logic [$clog2(C2_WIDTH)-1:0]             wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                   wr_data_i,
    input  logic                                    start_i,
    input  logic                                    key_select_i,
    input  logic                                    ready_i,
    input  logic                                    done_i,
    output logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] coeff_o,
    output logic                                    valid_o,
    output logic                                    key_select_o,
    output logic                                    busy_o,
    output logic                                    pass_done_o,
    output logic                                    err_o
);

    localparam int unsigned NUM_TILES = C2_WIDTH / C2_TILE_WIDTH;
    localparam int unsigned IdxW      = $clog2(NUM_TILES);
    localparam int unsigned CntW      = IdxW + 1;

    feeder_state_e state_q, state_d;
    logic [CntW-1:0] tile_idx_q, tile_idx_d;
    logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] coeff_q, coeff_d;
    logic valid_q, valid_d;
    logic key_q, key_d;
    logic pass_done_q, pass_done_d;
    logic err_q, err_d;
`ifdef RELIN_FEEDER_DUAL_PASS_EN
    logic second_q, second_d;
`endif

    logic                                     buf_we;
    logic [IdxW-1:0]                          rd_idx;
    logic [C2_TILE_WIDTH-1:0][DATA_WIDTH-1:0] rd_tile;

    // Writes only land while idle; elsewhere they are flagged as errors.
    assign buf_we = wr_en_i && (state_q == StIdle);

    relin_tile_buffer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .C2_WIDTH      (C2_WIDTH),
        .C2_TILE_WIDTH (C2_TILE_WIDTH)
    ) u_buffer (
        .clk_i         (clk),
        .we_i          (buf_we),
        .waddr_i       (wr_addr_i),
        .wdata_i       (wr_data_i),
        .rd_tile_idx_i (rd_idx),
        .rd_tile_o     (rd_tile)
    );

    // Next-state and output-register logic for the streaming FSM.
    always_comb begin
        state_d     = state_q;
        tile_idx_d  = tile_idx_q;
        coeff_d     = coeff_q;
        valid_d     = valid_q;
        key_d       = key_q;
        pass_done_d = 1'b0;
        err_d       = err_q;
        rd_idx      = '0;
`ifdef RELIN_FEEDER_DUAL_PASS_EN
        second_d    = second_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i && !wr_en_i) begin
                    coeff_d    = rd_tile;
                    valid_d    = 1'b1;
                    err_d      = 1'b0;
                    tile_idx_d = '0;
                    state_d    = StStream;
`ifdef RELIN_FEEDER_DUAL_PASS_EN
                    key_d      = 1'b0;
                    second_d   = 1'b0;
`else
                    key_d      = key_select_i;
`endif
                end
            end
            StStream: begin
                if (done_i) begin
                    err_d = 1'b1;
                end
                if (!valid_q) begin
                    // Re-arm after the one-cycle gap between dual passes.
                    coeff_d = rd_tile;
                    valid_d = 1'b1;
                end else if (ready_i) begin
                    if (tile_idx_q == CntW'(NUM_TILES - 1)) begin
                        valid_d = 1'b0;
                        state_d = StWaitDone;
                    end else begin
                        rd_idx  = IdxW'(tile_idx_q + CntW'(1));
                        coeff_d = rd_tile;
                    end
                    tile_idx_d = tile_idx_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (done_i) begin
`ifdef RELIN_FEEDER_DUAL_PASS_EN
                    if (!second_q) begin
                        second_d   = 1'b1;
                        key_d      = 1'b1;
                        tile_idx_d = '0;
                        state_d    = StStream;
                    end else begin
                        pass_done_d = 1'b1;
                        state_d     = StIdle;
                    end
`else
                    pass_done_d = 1'b1;
                    state_d     = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        if ((state_q != StIdle) && (wr_en_i || start_i)) begin
            err_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tile_idx_q  <= '0;
            coeff_q     <= '0;
            valid_q     <= 1'b0;
            key_q       <= 1'b0;
            pass_done_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef RELIN_FEEDER_DUAL_PASS_EN
            second_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tile_idx_q  <= tile_idx_d;
            coeff_q     <= coeff_d;
            valid_q     <= valid_d;
            key_q       <= key_d;
            pass_done_q <= pass_done_d;
            err_q       <= err_d;
`ifdef RELIN_FEEDER_DUAL_PASS_EN
            second_q    <= second_d;
`endif
        end
    end

    assign coeff_o      = coeff_q;
    assign valid_o      = valid_q;
    assign key_select_o = key_q;
    assign busy_o       = (state_q != StIdle);
    assign pass_done_o  = pass_done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_relin_tile_feeder.sv
// Self-checking bench for relin_tile_feeder against an array-based buffer model.
module tb_relin_tile_feeder;
    import relin_pkg::*;

    localparam int unsigned DW = RELIN_DATA_WIDTH;
    localparam int unsigned CW = RELIN_C2_WIDTH;
    localparam int unsigned TW = RELIN_C2_TILE_WIDTH;
    localparam int unsigned NT = CW / TW;
    localparam int unsigned TB = TW * DW;
    localparam int unsigned AW = $clog2(CW);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          start_i;
    logic          key_select_i;
    logic          ready_i;
    logic          done_i;
    tile_t         coeff_o;
    logic          valid_o;
    logic          key_select_o;
    logic          busy_o;
    logic          pass_done_o;
    logic          err_o;

    coeff_t ref_buf [CW];
    int checks   = 0;
    int failures = 0;

    relin_tile_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .start_i      (start_i),
        .key_select_i (key_select_i),
        .ready_i      (ready_i),
        .done_i       (done_i),
        .coeff_o      (coeff_o),
        .valid_o      (valid_o),
        .key_select_o (key_select_o),
        .busy_o       (busy_o),
        .pass_done_o  (pass_done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic tile_t exp_tile(input int k);
        tile_t t;
        for (int j = 0; j < int'(TW); j++) t[j] = ref_buf[k * int'(TW) + j];
        return t;
    endfunction

    task automatic check(input string tag, input logic [TB-1:0] obs, input logic [TB-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_coeff(input int a, input coeff_t d);
        @(negedge clk);
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(a);
        wr_data_i = d;
        ref_buf[a] = d;
    endtask

    task automatic start_pass(input bit key);
        @(negedge clk);
        start_i      = 1'b1;
        key_select_i = key;
        @(negedge clk);
        start_i = 1'b0;
        check("start_err_clear", err_o, 0);
        check("start_busy", busy_o, 1);
    endtask

    // Accepts tiles until stop_at have transferred; checks each presented tile against the model.
    task automatic run_stream(input bit exp_key, input int rmode, input bit inj_wr,
                              input int done_at, input int stop_at);
        int got = 0;
        int cyc = 0;
        bit dsent = 0;
        bit wsent = 0;
        while (got < stop_at && cyc < 4000) begin
            wr_en_i = 1'b0;
            done_i  = 1'b0;
            if (rmode == 0) check("valid_run", valid_o, 1);
            if (valid_o) begin
                check("tile_data", coeff_o, exp_tile(got));
                check("tile_key", key_select_o, exp_key);
            end
            ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (inj_wr && got == 5 && !wsent) begin
                wr_en_i   = 1'b1;
                wr_addr_i = '0;
                wr_data_i = 64'hDEAD;
                wsent     = 1'b1;
            end
            if (got == done_at && !dsent) begin
                done_i = 1'b1;
                dsent  = 1'b1;
            end
            if (valid_o && ready_i) got++;
            cyc++;
            @(negedge clk);
        end
        wr_en_i = 1'b0;
        done_i  = 1'b0;
        check("tile_count", got, stop_at);
    endtask

    task automatic finish_pass(input bit last);
        check("wait_valid_low", valid_o, 0);
        check("wait_busy", busy_o, 1);
        repeat (4) @(negedge clk);
        check("no_early_pass_done", pass_done_o, 0);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        if (last) begin
            check("pass_done_pulse", pass_done_o, 1);
            check("idle_after_done", busy_o, 0);
            @(negedge clk);
            check("pass_done_single", pass_done_o, 0);
        end else begin
            check("gap_valid_low", valid_o, 0);
            check("gap_busy", busy_o, 1);
            check("gap_no_pass_done", pass_done_o, 0);
        end
    endtask

    task automatic full_pass(input bit key, input int rmode, input bit inj_wr, input int done_at);
        start_pass(key);
`ifdef RELIN_FEEDER_DUAL_PASS_EN
        run_stream(1'b0, rmode, inj_wr, done_at, NT);
        finish_pass(1'b0);
        @(negedge clk);
        run_stream(1'b1, rmode, inj_wr, done_at, NT);
        finish_pass(1'b1);
`else
        run_stream(key, rmode, inj_wr, done_at, NT);
        finish_pass(1'b1);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        wr_en_i      = 1'b0;
        wr_addr_i    = '0;
        wr_data_i    = '0;
        start_i      = 1'b0;
        key_select_i = 1'b0;
        ready_i      = 1'b0;
        done_i       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_coeff", coeff_o, 0);
        check("rst_key", key_select_o, 0);
        check("rst_pass_done", pass_done_o, 0);
        check("rst_err", err_o, 0);
        rst = 1'b0;

        // Ramp data, key 1, ready held high.
        for (int i = 0; i < int'(CW); i++) write_coeff(i, coeff_t'(i));
        @(negedge clk);
        wr_en_i = 1'b0;
        full_pass(1'b1, 0, 1'b0, -1);

        // Reset in the middle of a stream after tile 3 has transferred.
        start_pass(1'b0);
        run_stream(1'b0, 0, 1'b0, -1, 4);
        rst = 1'b1;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_coeff", coeff_o, 0);
        @(negedge clk);
        check("midrst_err", err_o, 0);
        rst = 1'b0;
        full_pass(1'b0, 1, 1'b0, -1);

        // Random data with random backpressure.
        for (int i = 0; i < int'(CW); i++) write_coeff(i, {$urandom, $urandom});
        @(negedge clk);
        wr_en_i = 1'b0;
        full_pass(1'b1, 1, 1'b0, -1);

        // Write attempted mid-stream is dropped and flagged.
        full_pass(1'b0, 1, 1'b1, -1);
        check("wr_in_stream_err", err_o, 1);
        full_pass(1'b1, 0, 1'b0, -1);

        // start together with a write: write wins, no pass begins.
        @(negedge clk);
        start_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(3);
        wr_data_i = {$urandom, $urandom};
        ref_buf[3] = wr_data_i;
        @(negedge clk);
        start_i = 1'b0;
        wr_en_i = 1'b0;
        check("start_wr_busy", busy_o, 0);
        check("start_wr_valid", valid_o, 0);
        full_pass(1'b0, 1, 1'b0, -1);

        // Early done during streaming: flagged, stream still completes; next start clears.
        full_pass(1'b1, 1, 1'b0, 10);
        check("early_done_err", err_o, 1);
        full_pass(1'b0, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
